// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared requester ids and RAM latency helper for the particle memory path
package sim_pkg;

  typedef enum logic [1:0] {REQ_W, REQ_R0, REQ_R1} req_id_e;

  function automatic int rd_latency(input string perf);
    return (perf == "LOW_LATENCY") ? 1 : 2;
  endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// rtl/mem_tag_pipe.sv - shift register of {valid, id} tags that follows each access down the BRAM pipeline
module mem_tag_pipe
  import sim_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type id_t  = req_id_e
) (
  input  logic clk_in,
  input  logic rst,
  input  logic in_valid,
  input  id_t  in_id,
  output logic out_valid,
  output id_t  out_id
);

  logic [DEPTH-1:0] valid_q;
  id_t              id_q [DEPTH];

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= id_t'(0);
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
      valid_q[0] <= in_valid;
      id_q[0]    <= in_id;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/particle_mem_arbiter.sv
// rtl/particle_mem_arbiter.sv - single-port particle BRAM arbiter for updater write-back, reader and renderer
module particle_mem_arbiter
  import sim_pkg::*;
#(
  parameter int    ADDR_WIDTH      = 2,
  parameter int    DATA_WIDTH      = 16,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int    MAX_WR_BURST    = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  w_req,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_gnt,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_gnt,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_rvalid,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_gnt,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int RD_LAT = rd_latency(RAM_PERFORMANCE);
  localparam int BW     = $clog2(MAX_WR_BURST + 1);

  req_id_e         rr_ptr;
  logic [BW-1:0]   wr_burst;
  logic            any_rd, force_rd, pick_r0, rd_gnt;
  logic            tag_valid;
  req_id_e         tag_id;
  req_id_e         push_id;
  logic [DATA_WIDTH-1:0] r0_hold, r1_hold;

  // A full write burst yields exactly one slot to a waiting reader.
  always_comb begin
    any_rd   = r0_req | r1_req;
    force_rd = (wr_burst == BW'(MAX_WR_BURST)) && any_rd;
    pick_r0  = r0_req && ((rr_ptr == REQ_R0) || !r1_req);
    w_gnt    = !rst && w_req && !force_rd;
    r0_gnt   = !rst && any_rd && !w_gnt && pick_r0;
    r1_gnt   = !rst && any_rd && !w_gnt && !pick_r0;
    rd_gnt   = r0_gnt | r1_gnt;
    push_id  = r0_gnt ? REQ_R0 : (r1_gnt ? REQ_R1 : REQ_W);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rr_ptr   <= REQ_R0;
      wr_burst <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      if (r0_gnt)      rr_ptr <= REQ_R1;
      else if (r1_gnt) rr_ptr <= REQ_R0;

      if (rd_gnt || !any_rd)
        wr_burst <= '0;
      else if (w_gnt && (wr_burst != BW'(MAX_WR_BURST)))
        wr_burst <= wr_burst + BW'(1);

      mem_en <= w_gnt | rd_gnt;
      mem_we <= w_gnt;
      if (w_gnt) begin
        mem_addr <= w_addr;
        mem_din  <= w_data;
      end else if (r0_gnt) begin
        mem_addr <= r0_addr;
      end else if (r1_gnt) begin
        mem_addr <= r1_addr;
      end
    end
  end

  mem_tag_pipe #(
    .DEPTH (1 + RD_LAT),
    .id_t  (req_id_e)
  ) u_tag_pipe (
    .clk_in    (clk_in),
    .rst       (rst),
    .in_valid  (rd_gnt),
    .in_id     (push_id),
    .out_valid (tag_valid),
    .out_id    (tag_id)
  );

  // Return data bypasses straight from the RAM on the pulse and is held afterwards.
  assign r0_rvalid = tag_valid && (tag_id == REQ_R0);
  assign r1_rvalid = tag_valid && (tag_id == REQ_R1);
  assign r0_rdata  = r0_rvalid ? mem_dout : r0_hold;
  assign r1_rdata  = r1_rvalid ? mem_dout : r1_hold;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r0_hold <= '0;
      r1_hold <= '0;
    end else begin
      if (r0_rvalid) r0_hold <= mem_dout;
      if (r1_rvalid) r1_hold <= mem_dout;
    end
  end

endmodule

// File: tb/tb_particle_mem_arbiter.sv
// tb/tb_particle_mem_arbiter.sv - self-checking bench for particle_mem_arbiter with a BRAM model and return scoreboard
module tb_particle_mem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic        w_req  = 1'b0;
  logic [1:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic        w_gnt;
  logic        r0_req = 1'b0;
  logic [1:0]  r0_addr = '0;
  logic        r0_gnt;
  logic [15:0] r0_rdata;
  logic        r0_rvalid;
  logic        r1_req = 1'b0;
  logic [1:0]  r1_addr = '0;
  logic        r1_gnt;
  logic [15:0] r1_rdata;
  logic        r1_rvalid;
  logic [1:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        mem_en;
  logic [15:0] mem_dout;

  particle_mem_arbiter #(
    .ADDR_WIDTH      (2),
    .DATA_WIDTH      (16),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
    .MAX_WR_BURST    (4)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .w_req     (w_req),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_gnt     (w_gnt),
    .r0_req    (r0_req),
    .r0_addr   (r0_addr),
    .r0_gnt    (r0_gnt),
    .r0_rdata  (r0_rdata),
    .r0_rvalid (r0_rvalid),
    .r1_req    (r1_req),
    .r1_addr   (r1_addr),
    .r1_gnt    (r1_gnt),
    .r1_rdata  (r1_rdata),
    .r1_rvalid (r1_rvalid),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_en    (mem_en),
    .mem_dout  (mem_dout)
  );

  always #5 clk_in = ~clk_in;

  // Two-stage registered BRAM
  logic [15:0] ram [4];
  logic [15:0] p1 = '0;
  logic [15:0] p2 = '0;
  int          cyc = 0;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        p1 <= ram[mem_addr];
    end
    p2 <= p1;
  end
  assign mem_dout = (RD_LAT == 2) ? p2 : p1;

  typedef struct {
    logic        port;
    logic [15:0] data;
    int          due;
  } sb_t;

  typedef struct {
    logic        w;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        r0;
    logic [1:0]  a0;
    logic        r1;
    logic [1:0]  a1;
    logic [2:0]  eg;
  } vec_t;

  sb_t         sb [$];
  logic [15:0] ref_mem [4];
  logic [15:0] last_r0 = '0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [25];

  task automatic check_returns();
    sb_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL missing_rvalid port %0d due %0d now %0d", e.port, e.due, cyc);
    end
    if (r0_rvalid || r1_rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid got r0=%b r1=%b want none at cycle %0d", r0_rvalid, r1_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({r0_rvalid, r1_rvalid} != (e.port ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL rvalid_port got r0=%b r1=%b want port %0d", r0_rvalid, r1_rvalid, e.port);
        end
        checks++;
        if ((e.port ? r1_rdata : r0_rdata) != e.data) begin
          errors++;
          $display("FAIL rdata got %h want %h (port %0d)", e.port ? r1_rdata : r0_rdata, e.data, e.port);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL rd_latency got cycle %0d want %0d", cyc, e.due);
        end
        if (!e.port) last_r0 = e.data;
      end
    end
  endtask

  task automatic do_cycle(input logic w, input logic [1:0] wa, input logic [15:0] wd,
                          input logic r0, input logic [1:0] a0,
                          input logic r1, input logic [1:0] a1,
                          input logic [2:0] eg, input string tag);
    w_req = w;  w_addr = wa;  w_data = wd;
    r0_req = r0; r0_addr = a0;
    r1_req = r1; r1_addr = a1;
    @(negedge clk_in);
    check_returns();
    checks++;
    if ({w_gnt, r0_gnt, r1_gnt} != eg) begin
      errors++;
      $display("FAIL %s gnt{w,r0,r1} got %b want %b", tag, {w_gnt, r0_gnt, r1_gnt}, eg);
    end
    if (eg[2]) ref_mem[wa] = wd;
    if (eg[1]) sb.push_back('{port: 1'b0, data: ref_mem[a0], due: cyc + 1 + RD_LAT});
    if (eg[0]) sb.push_back('{port: 1'b1, data: ref_mem[a1], due: cyc + 1 + RD_LAT});
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input string tag);
    do_cycle(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, tag);
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && sb.size() > 0; k++) idle("drain");
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    w_req = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  initial begin
    int n;
    n = 0;
    for (int i = 0; i < 6; i++)
      vecs[n++] = '{1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b1, 2'd3, (i % 2 == 0) ? 3'b010 : 3'b001};
    for (int i = 0; i < 10; i++)
      vecs[n++] = '{1'b1, 2'd1, 16'hA000 + 16'(i), 1'b0, 2'd0, 1'b1, 2'd1,
                    (i == 4 || i == 9) ? 3'b001 : 3'b100};
    vecs[n++] = '{1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 1'b0, 2'd0, 3'b000};
    vecs[n++] = '{1'b1, 2'd1, 16'hBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 3'b100};
    vecs[n++] = '{1'b0, 2'd0, 16'h0,    1'b1, 2'd1, 1'b0, 2'd0, 3'b010};
    vecs[n++] = '{1'b1, 2'd3, 16'h5A5A, 1'b1, 2'd3, 1'b0, 2'd0, 3'b100};
    vecs[n++] = '{1'b0, 2'd0, 16'h0,    1'b1, 2'd3, 1'b0, 2'd0, 3'b010};
    vecs[n++] = '{1'b0, 2'd0, 16'h0,    1'b1, 2'd0, 1'b1, 2'd2, 3'b001};
    vecs[n++] = '{1'b0, 2'd0, 16'h0,    1'b1, 2'd0, 1'b0, 2'd0, 3'b010};
    vecs[n++] = '{1'b1, 2'd0, 16'h0C0C, 1'b1, 2'd2, 1'b0, 2'd0, 3'b100};
    vecs[n++] = '{1'b0, 2'd0, 16'h0,    1'b1, 2'd0, 1'b0, 2'd0, 3'b010};

    // Requests asserted during reset must not be granted
    rst = 1'b1;
    w_req = 1'b1; r0_req = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check_val("rst_gnt", {13'h0, w_gnt, r0_gnt, r1_gnt}, 16'h0);
    check_val("rst_mem_en_we", {14'h0, mem_en, mem_we}, 16'h0);
    check_val("rst_mem_addr", {14'h0, mem_addr}, 16'h0);
    check_val("rst_mem_din", mem_din, 16'h0);
    check_val("rst_r0_rdata", r0_rdata, 16'h0);
    check_val("rst_r1_rdata", r1_rdata, 16'h0);
    check_val("rst_rvalid", {14'h0, r0_rvalid, r1_rvalid}, 16'h0);
    w_req = 1'b0; r0_req = 1'b0;
    rst = 1'b0;

    do_cycle(1'b1, 2'd0, 16'h1111, 1'b0, 2'd0, 1'b0, 2'd0, 3'b100, "init0");
    check_val("wr_cmd_en_we", {14'h0, mem_en, mem_we}, 16'h3);
    check_val("wr_cmd_din", mem_din, 16'h1111);
    do_cycle(1'b1, 2'd1, 16'h2222, 1'b0, 2'd0, 1'b0, 2'd0, 3'b100, "init1");
    do_cycle(1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 1'b0, 2'd0, 3'b100, "init2");
    do_cycle(1'b1, 2'd3, 16'h4444, 1'b0, 2'd0, 1'b0, 2'd0, 3'b100, "init3");

    do_cycle(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 1'b0, 2'd0, 3'b010, "t1_gnt");
    check_val("t1_cmd_en_we", {14'h0, mem_en, mem_we}, 16'h2);
    check_val("t1_cmd_addr", {14'h0, mem_addr}, 16'h2);
    drain();

    apply_reset();
    for (int i = 0; i < 25; i++)
      do_cycle(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].r0, vecs[i].a0,
               vecs[i].r1, vecs[i].a1, vecs[i].eg, $sformatf("vec%0d", i));
    drain();
    idle("hold");
    check_val("r0_rdata_hold", r0_rdata, last_r0);

    // Reset with two reads in flight
    do_cycle(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b010, "t6_r0");
    do_cycle(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 2'd3, 3'b001, "t6_r1");
    w_req = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    rst = 1'b1;
    #1;
    check_val("t6_rvalid", {14'h0, r0_rvalid, r1_rvalid}, 16'h0);
    check_val("t6_mem_en", {15'h0, mem_en}, 16'h0);
    check_val("t6_mem_addr", {14'h0, mem_addr}, 16'h0);
    check_val("t6_r0_rdata", r0_rdata, 16'h0);
    check_val("t6_r1_rdata", r1_rdata, 16'h0);
    sb.delete();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) idle("t6_quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
